// File: rtl/ram_lsu_pkg.sv
// ram_lsu_pkg: size encodings, FSM states and lane helpers for the RAM load/store unit
package ram_lsu_pkg;
   localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3;
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
   function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_d,
                                              input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] mask;
      mask = size == SZ_B ? 32'h0000_00FF : size == SZ_H ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      mask = mask << {lane, 3'b000};
      return (old_w & ~mask) | ((new_d << {lane, 3'b000}) & mask);
   endfunction
   function automatic logic [31:0] lane_ext(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic uns);
      logic [31:0] s;
      s = word >> {lane, 3'b000};
      return size == SZ_B ? {{24{~uns & s[7]}}, s[7:0]} :
             size == SZ_H ? {{16{~uns & s[15]}}, s[15:0]} : s;
   endfunction
endpackage

// File: rtl/ram_lsu_if.sv
// ram_lsu_if: request/response handshake and data-RAM port bundle of the load/store unit
interface ram_lsu_if #(parameter int ADDR_WIDTH = 8);
   logic                  req_valid, req_ready, req_wen, req_unsigned;
   logic [1:0]            req_size;
   logic [31:0]           req_addr, req_wdata;
   logic                  resp_valid, resp_ready, resp_err;
   logic [31:0]           resp_rdata;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
   logic [31:0]           ram_wdata, ram_rdata;
   modport slave (input req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
                  resp_ready, ram_rdata,
                  output req_ready, resp_valid, resp_rdata, resp_err,
                  ram_we, ram_waddr, ram_wdata, ram_raddr);
   modport master (output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
                   resp_ready, ram_rdata,
                   input req_ready, resp_valid, resp_rdata, resp_err,
                   ram_we, ram_waddr, ram_wdata, ram_raddr);
endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: extracts the addressed byte/half lane of a word and sign/zero-extends it
module lsu_load_ext import ram_lsu_pkg::*; (
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   output logic [31:0] o_data
);
   assign o_data = lane_ext(i_word, i_lane, i_size, i_uns);
endmodule

// File: rtl/ram_lsu.sv
// ram_lsu: load/store front-end of the data RAM with single-cycle sub-word read-modify-write
module ram_lsu import ram_lsu_pkg::*; #(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
   input logic       clk,
   input logic       rst,
   ram_lsu_if.slave  bus
);
   state_t                r_state;
   logic                  r_wen, r_uns, r_err;
   logic [1:0]            r_size, r_lane;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [31:0]           r_wdata, r_rdata;
   logic [31:0]           w_off, w_ext;
   logic                  w_err;
   // BASE_ADDR is word aligned, so offset alignment bits equal address alignment bits
   assign w_off = bus.req_addr - BASE_ADDR;
   assign w_err = bus.req_size == SZ_X || (bus.req_size == SZ_H && w_off[0]) ||
                  (bus.req_size == SZ_W && w_off[1:0] != 2'b00) ||
                  bus.req_addr < BASE_ADDR || w_off[31:ADDR_WIDTH+2] != '0;
   lsu_load_ext u_ext (.i_word(bus.ram_rdata), .i_lane(r_lane), .i_size(r_size), .i_uns(r_uns), .o_data(w_ext));
   assign bus.req_ready  = r_state == ST_IDLE;
   assign bus.resp_valid = r_state == ST_RESP;
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_err   = r_err;
   assign bus.ram_we     = r_state == ST_ACCESS && r_wen && !r_err && !rst;
   assign bus.ram_waddr  = r_idx;
   assign bus.ram_raddr  = r_idx;
   assign bus.ram_wdata  = lane_merge(bus.ram_rdata, r_wdata, r_lane, r_size);
   // request capture, load-data registration and IDLE -> ACCESS -> RESP sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.req_valid) begin
               r_state <= ST_ACCESS;
               r_wen   <= bus.req_wen;
               r_size  <= bus.req_size;
               r_uns   <= bus.req_unsigned;
               r_lane  <= w_off[1:0];
               r_idx   <= w_off[ADDR_WIDTH+1:2];
               r_wdata <= bus.req_wdata;
               r_err   <= w_err;
            end
            ST_ACCESS: begin
               r_rdata <= (r_wen || r_err) ? '0 : w_ext;
               r_state <= ST_RESP;
            end
            ST_RESP: if (bus.resp_ready) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: randomized and directed checks of ram_lsu against a byte-array memory model
module tb_ram_lsu;
   localparam int          AW   = 8;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          NB   = 4 << AW;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   ram_lsu_if #(.ADDR_WIDTH(AW)) bus ();
   ram_lsu #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));
   logic [31:0] mem [2**AW];
   logic pl_we = 1'b0;
   logic [AW-1:0] pl_a = '0;
   logic [31:0] pl_d = '0;
   assign bus.ram_rdata = mem[bus.ram_raddr];
   always @(posedge clk) begin
      if (pl_we) mem[pl_a] <= pl_d;
      else if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
   end
   logic [7:0] ref_b [NB];
   int checks = 0, errors = 0, cyc = 0, acc = 0;
   bit busy = 0, exp_we = 0, chk_on = 0;
   logic [31:0] exp_rd = '0;
   logic exp_err = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [1:0] s);
      return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
   endfunction
   function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
      logic [32:0] lim;
      lim = {1'b0, BASE} + 33'(NB);
      return s == 2'd3 || (a % 32'(nbytes(s))) != 0 || a < BASE || {1'b0, a} >= lim;
   endfunction
   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic uns);
      int o, n;
      logic [31:0] v;
      o = int'(a - BASE);
      n = nbytes(s);
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_b[o+i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction
   task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      int o;
      o = int'(a - BASE);
      for (int i = 0; i < nbytes(s); i++) ref_b[o+i] = d[8*i +: 8];
   endtask

   // per-cycle comparison of DUT outputs against the transaction the bench has in flight
   always @(negedge clk) begin
      if (chk_on) begin
         if (rst) chk("ram_we_in_rst", 32'(bus.ram_we), 32'd0);
         else begin
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            chk("resp_valid", 32'(bus.resp_valid), 32'(busy && cyc > acc));
            chk("ram_we", 32'(bus.ram_we), 32'(busy && cyc == acc && exp_we));
            if (bus.resp_valid) begin
               chk("resp_rdata", bus.resp_rdata, exp_rd);
               chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
            end
         end
      end
   end

   // entered and left at posedge+1 with the DUT idle
   task automatic txn(input logic wen, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] d, input int stall, output logic [31:0] rd, output logic er);
      int w;
      bit hs;
      logic e_err;
      logic [31:0] e_rd;
      w = 0;
      e_err = model_err(a, sz);
      e_rd = (wen || e_err) ? 32'd0 : model_load(a, sz, uns);
      bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_size = sz;
      bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = d;
      @(posedge clk); #1;
      busy = 1; acc = cyc; exp_err = e_err; exp_rd = e_rd; exp_we = wen && !e_err;
      if (wen && !e_err) model_store(a, sz, d);
      bus.req_wen = 1'($urandom); bus.req_size = 2'($urandom);
      bus.req_addr = BASE + ($urandom & 32'h3FC); bus.req_wdata = $urandom;
      bus.resp_ready = 1'b0;
      rd = '0; er = 1'b0;
      while (1) begin
         if (bus.resp_valid) begin
            if (stall == 0) bus.resp_ready = 1'b1;
            else stall--;
         end
         hs = bus.resp_valid && bus.resp_ready;
         rd = bus.resp_rdata; er = bus.resp_err;
         @(posedge clk); #1;
         if (hs) break;
         if (++w > 20) begin
            checks++; errors++;
            $display("FAIL resp_timeout: no response handshake within 20 cycles");
            break;
         end
      end
      busy = 0; bus.resp_ready = 1'b0; bus.req_valid = 1'b0;
   endtask

   // reset while a request is in ACCESS (ph=1, store) or RESP (ph=2, load)
   task automatic rst_mid(input int ph);
      logic [31:0] a;
      a = BASE + 32'h20;
      bus.req_valid = 1'b1; bus.req_wen = (ph == 1); bus.req_size = 2'd2;
      bus.req_unsigned = 1'b0; bus.req_addr = a; bus.req_wdata = 32'h1234_5678;
      exp_rd = (ph == 1) ? 32'd0 : model_load(a, 2'd2, 1'b0);
      @(posedge clk); #1;
      busy = 1; acc = cyc; exp_err = 1'b0; exp_we = 1'b0;
      bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
      if (ph == 2) begin
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; busy = 0;
      chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
   endtask

   logic [31:0] rd, a, d;
   logic er;
   logic [1:0] sz;
   initial begin
      bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2**AW; i++) begin
         pl_we = 1'b1; pl_a = AW'(i); pl_d = $urandom;
         for (int j = 0; j < 4; j++) ref_b[4*i+j] = pl_d[8*j +: 8];
         @(posedge clk); #1;
      end
      pl_we = 1'b0; chk_on = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rdata", bus.resp_rdata, 32'd0);
      chk("reset_err", 32'(bus.resp_err), 32'd0);
      @(posedge clk); #1;
      txn(1, 2'd2, 0, BASE + 32'h10, 32'hDEAD_BEEF, 0, rd, er);
      chk("t1_mem", mem[4], 32'hDEAD_BEEF);
      txn(0, 2'd2, 0, BASE + 32'h10, 32'h0, 0, rd, er);
      chk("t1_lw", rd, 32'hDEAD_BEEF);
      chk("t1_err", 32'(er), 32'd0);
      txn(1, 2'd2, 0, BASE + 32'h10, 32'h1122_3344, 0, rd, er);
      txn(1, 2'd0, 0, BASE + 32'h13, 32'h0000_005A, 0, rd, er);
      chk("t2_mem_sb", mem[4], 32'h5A22_3344);
      txn(0, 2'd0, 0, BASE + 32'h13, 32'h0, 0, rd, er);
      chk("t2_lb", rd, 32'h0000_005A);
      txn(1, 2'd0, 0, BASE + 32'h13, 32'hFFFF_FFF0, 1, rd, er);
      txn(0, 2'd0, 0, BASE + 32'h13, 32'h0, 0, rd, er);
      chk("t2_lb_neg", rd, 32'hFFFF_FFF0);
      txn(0, 2'd0, 1, BASE + 32'h13, 32'h0, 0, rd, er);
      chk("t2_lbu", rd, 32'h0000_00F0);
      txn(1, 2'd2, 0, BASE, 32'hAAAA_AAAA, 0, rd, er);
      txn(1, 2'd1, 0, BASE + 32'h2, 32'h0000_8001, 0, rd, er);
      chk("t3_mem_sh", mem[0], 32'h8001_AAAA);
      txn(0, 2'd1, 0, BASE + 32'h2, 32'h0, 0, rd, er);
      chk("t3_lh", rd, 32'hFFFF_8001);
      txn(0, 2'd1, 1, BASE + 32'h2, 32'h0, 0, rd, er);
      chk("t3_lhu", rd, 32'h0000_8001);
      txn(0, 2'd1, 0, BASE + 32'h1, 32'h0, 0, rd, er);
      chk("t4_lh_mis_err", 32'(er), 32'd1);
      chk("t4_lh_mis_rd", rd, 32'd0);
      txn(1, 2'd2, 0, BASE + 32'h2, 32'hCAFE_F00D, 0, rd, er);
      chk("t4_sw_mis_err", 32'(er), 32'd1);
      txn(0, 2'd3, 0, BASE + 32'h10, 32'h0, 0, rd, er);
      chk("t4_size3_err", 32'(er), 32'd1);
      chk("t4_size3_rd", rd, 32'd0);
      txn(1, 2'd2, 0, 32'h7FFF_FFFC, 32'hCAFE_F00D, 0, rd, er);
      chk("t4_below_err", 32'(er), 32'd1);
      txn(1, 2'd2, 0, BASE + 32'h400, 32'hCAFE_F00D, 0, rd, er);
      chk("t4_above_err", 32'(er), 32'd1);
      chk("t4_mem0_kept", mem[0], 32'h8001_AAAA);
      txn(0, 2'd2, 0, BASE + 32'h3FC, 32'h0, 0, rd, er);
      chk("t4_last_word_ok", 32'(er), 32'd0);
      txn(0, 2'd2, 0, BASE + 32'h10, 32'h0, 5, rd, er);
      chk("t5_stall_rd", rd, 32'hF022_3344);
      rst_mid(1);
      rst_mid(2);
      for (int n = 0; n < 300; n++) begin
         sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0: a = BASE - 32'($urandom_range(1, 16));
            1: a = BASE + 32'(NB) + 32'($urandom_range(0, 15));
            2, 3: a = BASE + 32'($urandom_range(0, NB - 1));
            default: a = BASE + (32'($urandom_range(0, NB - 1)) & ~(32'(nbytes(sz)) - 32'd1));
         endcase
         d = $urandom;
         txn(1'($urandom), sz, 1'($urandom), a, d, $urandom_range(0, 3), rd, er);
      end
      for (int i = 0; i < 2**AW; i++)
         chk($sformatf("final_mem[%0d]", i), mem[i], {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
